// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a req/gnt/rvalid bus and
// buffers returned words in an in-order FIFO for the core. Redirect flushes and drops stale reads.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   sum_t;

  logic [31:0] fetch_pc_q;
  cnt_t        occ_q, outst_q, drop_q;
  ptr_t        rd_ptr_q, wr_ptr_q, ifq_rd_q, ifq_wr_q;
  logic [31:0] word_q  [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] ifq_pc_q[DEPTH];

  sum_t credit_sum;
  logic grant, rsp_drop, rsp_live, rsp_kill, pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    credit_sum = sum_t'(occ_q) + sum_t'(outst_q) + sum_t'(drop_q);
    mem_req    = !reset && !redirect && (credit_sum < sum_t'(DEPTH));
    mem_addr   = fetch_pc_q;
    grant      = mem_req && mem_gnt;
    rsp_drop   = mem_rvalid && (drop_q != '0);
    rsp_live   = mem_rvalid && (drop_q == '0) && (outst_q != '0);
    // A response in the redirect cycle belongs to a stale read; protocol-error responses excluded.
    rsp_kill   = mem_rvalid && ((drop_q != '0) || (outst_q != '0));
    inst_valid = (occ_q != '0);
    pop        = inst_valid && inst_ready;
    inst       = inst_valid ? word_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? pc_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ifq_rd_q   <= '0;
      ifq_wr_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= drop_q + outst_q - cnt_t'(rsp_kill);
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ifq_rd_q   <= '0;
      ifq_wr_q   <= '0;
    end else begin
      if (grant) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        ifq_wr_q   <= ifq_wr_q + ptr_t'(1);
      end
      if (rsp_drop) drop_q <= drop_q - cnt_t'(1);
      if (rsp_live) begin
        ifq_rd_q <= ifq_rd_q + ptr_t'(1);
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      outst_q <= outst_q + cnt_t'(grant) - cnt_t'(rsp_live);
      occ_q   <= occ_q + cnt_t'(rsp_live) - cnt_t'(pop);
    end
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clock) begin
    if (grant) ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
    if (rsp_live) begin
      word_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= ifq_pc_q[ifq_rd_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: behavioural memory with programmable latency, a vector table
// for reset/stream/stall behaviour, and hand sequences for grant stalls, redirects, wrap, reset.
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset, redirect, mem_gnt, mem_rvalid, inst_ready;
  logic [31:0] redirect_pc, mem_rdata, mem_addr, inst, inst_pc;
  logic        mem_req, inst_valid;

  inst_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  initial forever #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } dlv_t;
  typedef struct {
    bit rst; bit rdy; bit req; logic [31:0] addr; bit vld; logic [31:0] pc;
  } vec_t;

  pend_t pend[$];
  dlv_t  dq[$];
  vec_t  vt[23];
  int    cyc = 0;
  int    lat = 1;
  bit    gnt_en = 1'b1;
  int    checks = 0;
  int    errors = 0;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_inst, obs_pc;

  function automatic vec_t mk(bit rst, bit rdy, bit req, logic [31:0] addr, bit vld,
                              logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: memory drives its outputs, DUT outputs are observed, then the edge.
  task automatic tick();
    pend_t p;
    if (reset) pend.delete();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = p.addr ^ 32'hA5A5_0000;
    end
    mem_gnt = gnt_en;
    #1;
    obs_req = mem_req; obs_addr = mem_addr; obs_valid = inst_valid;
    obs_inst = inst; obs_pc = inst_pc;
    if (mem_req && mem_gnt) begin
      p.addr = mem_addr; p.due = cyc + lat;
      pend.push_back(p);
    end
    if (inst_valid && inst_ready && !redirect && !reset) begin
      dq.push_back('{pc: inst_pc, w: inst});
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; inst_ready = 1'b1; gnt_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    dq.delete();
  endtask

  task automatic check_stream(input string nm, input logic [31:0] start, input int n);
    logic [31:0] pc;
    chk({nm, "_count"}, 32'(dq.size() >= n), 32'd1);
    pc = start;
    for (int i = 0; i < n && i < dq.size(); i++) begin
      chk($sformatf("%s_pc%0d", nm, i), dq[i].pc, pc);
      chk($sformatf("%s_inst%0d", nm, i), dq[i].w, pc ^ 32'hA5A5_0000);
      pc = pc + 32'd4;
    end
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_valid) break;
    end
    chk({nm, "_valid"}, 32'(obs_valid), 32'd1);
    chk({nm, "_pc"}, obs_pc, exp_pc);
    chk({nm, "_inst"}, obs_inst, exp_pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, steady stream, 10-cycle stall filling the FIFO, then release.
    vt[0] = mk(1, 1, 0, 0, 0, 0);
    vt[1] = mk(1, 1, 0, 0, 0, 0);
    vt[2] = mk(0, 1, 1, 32'h100, 0, 0);
    vt[3] = mk(0, 1, 1, 32'h104, 0, 0);
    vt[4] = mk(0, 1, 1, 32'h108, 1, 32'h100);
    vt[5] = mk(0, 1, 1, 32'h10C, 1, 32'h104);
    vt[6] = mk(0, 1, 1, 32'h110, 1, 32'h108);
    vt[7] = mk(0, 0, 1, 32'h114, 1, 32'h10C);
    vt[8] = mk(0, 0, 1, 32'h118, 1, 32'h10C);
    for (int i = 9; i < 17; i++) vt[i] = mk(0, 0, 0, 0, 1, 32'h10C);
    vt[17] = mk(0, 1, 0, 0, 1, 32'h10C);
    vt[18] = mk(0, 1, 1, 32'h11C, 1, 32'h110);
    vt[19] = mk(0, 1, 1, 32'h120, 1, 32'h114);
    vt[20] = mk(0, 1, 1, 32'h124, 1, 32'h118);
    vt[21] = mk(0, 1, 1, 32'h128, 1, 32'h11C);
    vt[22] = mk(0, 1, 1, 32'h12C, 1, 32'h120);

    @(posedge clock);
    #1;
    lat = 1;
    for (int i = 0; i < 23; i++) begin
      reset = vt[i].rst;
      inst_ready = vt[i].rdy;
      if (i == 2) dq.delete();
      tick();
      chk($sformatf("v%0d_req", i), 32'(obs_req), 32'(vt[i].req));
      if (vt[i].req) chk($sformatf("v%0d_addr", i), obs_addr, vt[i].addr);
      if (i > 0) chk($sformatf("v%0d_valid", i), 32'(obs_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("v%0d_pc", i), obs_pc, vt[i].pc);
        chk($sformatf("v%0d_inst", i), obs_inst, vt[i].pc ^ 32'hA5A5_0000);
      end else if (i > 0 && vt[i].rst) begin
        chk($sformatf("v%0d_pc_rst", i), obs_pc, 32'h0);
        chk($sformatf("v%0d_inst_rst", i), obs_inst, 32'h0);
      end
    end
    check_stream("stall_stream", 32'h100, 9);

    // Grant withheld for 3 cycles: address must hold at 0x108.
    do_reset();
    lat = 1;
    tick();
    tick();
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gnt_hold_req%0d", i), 32'(obs_req), 32'd1);
      chk($sformatf("gnt_hold_addr%0d", i), obs_addr, 32'h108);
    end
    gnt_en = 1'b1;
    tick();
    chk("gnt_release_addr", obs_addr, 32'h108);
    tick();
    chk("gnt_next_addr", obs_addr, 32'h10C);
    for (int i = 0; i < 6; i++) tick();
    check_stream("gnt_stream", 32'h100, 5);

    // 3-cycle memory, redirect with 2 reads in flight.
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h2002;
    tick();
    chk("rdr_req_low", 32'(obs_req), 32'd0);
    redirect = 1'b0;
    dq.delete();
    tick();
    chk("rdr_req", 32'(obs_req), 32'd1);
    chk("rdr_addr", obs_addr, 32'h2000);
    chk("rdr_valid_low", 32'(obs_valid), 32'd0);
    wait_valid("rdr_first", 32'h2000);
    for (int i = 0; i < 4; i++) tick();
    check_stream("rdr_stream", 32'h2000, 3);

    // Redirect coinciding with a response and a handshake, then a second redirect.
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h800;
    tick();
    redirect_pc = 32'h400;
    tick();
    chk("b2b_req_low", 32'(obs_req), 32'd0);
    redirect = 1'b0;
    dq.delete();
    tick();
    chk("b2b_req", 32'(obs_req), 32'd1);
    chk("b2b_addr", obs_addr, 32'h400);
    chk("b2b_valid_low", 32'(obs_valid), 32'd0);
    for (int i = 0; i < 19; i++) tick();
    chk("b2b_throughput", 32'(dq.size()), 32'd17);
    check_stream("b2b_stream", 32'h400, 17);

    // Address wrap at the top of the address space.
    do_reset();
    lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    dq.delete();
    tick();
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", obs_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", obs_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) tick();
    check_stream("wrap_stream", 32'hFFFF_FFF8, 4);

    // Reset mid-stream with reads outstanding.
    lat = 3;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_pending", 32'(pend.size() >= 2), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_req", 32'(obs_req), 32'd0);
    reset = 1'b0;
    dq.delete();
    tick();
    chk("mid_valid_low", 32'(obs_valid), 32'd0);
    chk("mid_req", 32'(obs_req), 32'd1);
    chk("mid_addr", obs_addr, 32'h100);
    wait_valid("mid_first", 32'h100);
    for (int i = 0; i < 4; i++) tick();
    check_stream("mid_stream", 32'h100, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the single-cycle execute core. Owns the fetch PC, issues word reads to instruction memory over a request/grant/response bus, and buffers returned words in an in-order FIFO. Delivers instructions to the core with a valid/ready handshake. Supports a one-cycle redirect (branch/jump target) that flushes the buffer and discards in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- DEPTH, 4, instruction FIFO entries and max in-flight credits (power of two, ≥2)

- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high reset
- REDIRECT  in  1  load new fetch PC, flush buffer and in-flight reads
- REDIRECT_PC  in  32  redirect target; bits [1:0] forced to 0
- MEM_REQ  out  1  read request valid
- MEM_ADDR  out  32  word-aligned read address
- MEM_GNT  in  1  request accepted this cycle (when MEM_REQ high)
- MEM_RVALID  in  1  read data returned; in order, one per grant, earliest 1 cycle after grant
- MEM_RDATA  in  32  returned instruction word
- INST_VALID  out  1  INST/INST_PC hold a valid instruction
- INST  out  32  instruction word (FIFO head)
- INST_PC  out  32  address of INST
- INST_READY  in  1  core consumes head this cycle

## Operation
- State: fetch_pc (32b), FIFO of DEPTH entries {word, pc}, outstanding counter (granted, not yet returned, live), drop counter (granted before a redirect, not yet returned).
- Credit rule: MEM_REQ = !REDIRECT && (occupancy + outstanding + drop < DEPTH). MEM_ADDR = fetch_pc.
- Grant: MEM_REQ && MEM_GNT → fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0), outstanding +1. Address pc of the request is pushed into a DEPTH-deep in-flight pc queue.
- MEM_REQ without grant: MEM_ADDR held stable; request stays asserted until granted or REDIRECT.
- Response: MEM_RVALID with drop>0 → discard, drop −1. Otherwise push {MEM_RDATA, in-flight pc} to FIFO, outstanding −1. Credit rule guarantees no overflow.
- Pop: INST_VALID && INST_READY removes head. Push and pop same cycle: occupancy unchanged, order preserved, no bubble.
- REDIRECT (priority over everything except RESET): fetch_pc ← {REDIRECT_PC[31:2],2'b00}; FIFO and in-flight pc queue cleared; drop ← drop + outstanding − (MEM_RVALID ? 1 : 0) (response arriving in redirect cycle is discarded); outstanding ← 0. Handshake in the redirect cycle is ignored by this block. Back-to-back redirects accumulate drop correctly; last target wins.
- MEM_RVALID with drop=0 and outstanding=0 is a protocol error; response ignored.

## Timing
- Reset values: fetch_pc=RESET_PC, occupancy=outstanding=drop=0, INST_VALID=0, INST=0, INST_PC=0. MEM_REQ high in first cycle after RESET falls.
- MEM_REQ low in any cycle RESET or REDIRECT is high.
- Latency: grant at t, MEM_RVALID at t+1 → INST_VALID at t+2 (FIFO output registered). Redirect at t → MEM_REQ with target at t+1, INST_VALID low at t+1.
- Throughput: one instruction per cycle sustained with single-cycle memory and INST_READY high, DEPTH≥3.
- Full FIFO + INST_READY low: MEM_REQ low, outputs stable until pop.
- RESET mid-operation discards all state; memory must be reset in the same cycle (no responses to pre-reset grants).

## Test plan
- Reset RESET_PC=0x100, always-grant 1-cycle memory returning data=addr^0xA5A5_0000, INST_READY=1 → MEM_ADDR 0x100,0x104,… ; INST_PC 0x100 at cycle 2 after reset, then +4 every cycle, INST matches.
- INST_READY low 10 cycles → occupancy reaches 4, MEM_REQ low, INST/INST_PC stable; release → 0x100..0x10C then 0x110 with no gap or duplicate.
- MEM_GNT low 3 cycles with MEM_REQ high → MEM_ADDR held 0x108; after grant sequence continues at 0x10C.
- Memory with 3-cycle latency, 2 outstanding, REDIRECT to 0x2002 → both stale responses dropped, next INST_PC=0x2000, INST from 0x2000.
- REDIRECT in same cycle as MEM_RVALID and INST_READY, followed next cycle by REDIRECT to 0x400 → only 0x400 stream delivered, drop returns to 0.
- fetch_pc at 0xFFFF_FFFC → next MEM_ADDR 0x0000_0000; RESET asserted mid-stream with 2 outstanding → INST_VALID=0 next cycle, fetch restarts at RESET_PC.
